// File: rtl/transmitter_camera_2_if.sv
// Strobe, coordinate bus and serial-side status between camera_top_level and the
// camera-2 UART frame transmitter.
interface transmitter_camera_2_if;
  logic        transmit_xy_update;
  logic [11:0] hand_x_left_top;
  logic [11:0] hand_y_left_top;
  logic [11:0] hand_x_left_bottom;
  logic [11:0] hand_y_left_bottom;
  logic        uart_txd;
  logic        busy;
  logic        done;

  modport master (
    output transmit_xy_update, hand_x_left_top, hand_y_left_top,
           hand_x_left_bottom, hand_y_left_bottom,
    input  uart_txd, busy, done
  );

  modport slave (
    input  transmit_xy_update, hand_x_left_top, hand_y_left_top,
           hand_x_left_bottom, hand_y_left_bottom,
    output uart_txd, busy, done
  );
endinterface

// File: rtl/transmitter_camera_2.sv
// Sends a snapshot of the left-hand coordinates to camera 1 as a 9-byte 8N1 frame:
// three 0xFF sync bytes followed by six packed coordinate bytes.
module transmitter_camera_2 #(
  parameter int CLKS_PER_BIT = 564
) (
  input  logic                   clk_65mhz,
  input  logic                   sys_rst,
  transmitter_camera_2_if.slave  bus
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] clk_cnt;
  logic [3:0]    byte_idx;
  logic [2:0]    bit_idx;
  logic [47:0]   snapshot;
  logic [7:0]    cur_byte;
  logic          txd_q;
  logic          busy_q;
  logic          done_q;

  // Bytes 0..2 are the sync header; the rest slice the 48-bit snapshot MSB first.
  always_comb begin
    cur_byte = 8'hFF;
    case (byte_idx)
      4'd3:    cur_byte = snapshot[47:40];
      4'd4:    cur_byte = snapshot[39:32];
      4'd5:    cur_byte = snapshot[31:24];
      4'd6:    cur_byte = snapshot[23:16];
      4'd7:    cur_byte = snapshot[15:8];
      4'd8:    cur_byte = snapshot[7:0];
      default: cur_byte = 8'hFF;
    endcase
  end

  // The line level for the next bit is loaded on the same edge that changes state,
  // so every bit is held for exactly CLKS_PER_BIT cycles with no gap between bytes.
  always_ff @(posedge clk_65mhz or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= IDLE;
      clk_cnt  <= '0;
      byte_idx <= '0;
      bit_idx  <= '0;
      snapshot <= '0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          txd_q  <= 1'b1;
          busy_q <= 1'b0;
          if (bus.transmit_xy_update) begin
            snapshot <= {bus.hand_x_left_top, bus.hand_y_left_top,
                         bus.hand_x_left_bottom, bus.hand_y_left_bottom};
            byte_idx <= '0;
            bit_idx  <= '0;
            clk_cnt  <= '0;
            txd_q    <= 1'b0;
            busy_q   <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (clk_cnt == LAST) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            txd_q   <= cur_byte[0];
            state   <= DATA;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        DATA: begin
          if (clk_cnt == LAST) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
              txd_q <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd_q   <= cur_byte[bit_idx + 3'd1];
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        STOP: begin
          if (clk_cnt == LAST) begin
            clk_cnt <= '0;
            if (byte_idx == 4'd8) begin
              txd_q  <= 1'b1;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= IDLE;
            end else begin
              byte_idx <= byte_idx + 4'd1;
              txd_q    <= 1'b0;
              state    <= START;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.uart_txd = txd_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_transmitter_camera_2.sv
// Directed bench for transmitter_camera_2 at CLKS_PER_BIT=4: decodes frames off the
// serial line with a cycle-accurate UART sampler and compares against hand-built frames.
module tb_transmitter_camera_2;
  localparam int CPB = 4;
  localparam int FRAME_CYCLES = 90 * CPB;

  logic clk_65mhz = 1'b0;
  logic sys_rst;
  int   checks = 0;
  int   failures = 0;
  int   done_count = 0;

  transmitter_camera_2_if ifc();

  transmitter_camera_2 #(.CLKS_PER_BIT(CPB)) dut (
    .clk_65mhz (clk_65mhz),
    .sys_rst   (sys_rst),
    .bus       (ifc)
  );

  always #5 clk_65mhz = ~clk_65mhz;

  always @(negedge clk_65mhz) if (ifc.done === 1'b1) done_count++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic set_coords(input logic [11:0] xt, input logic [11:0] yt,
                            input logic [11:0] xb, input logic [11:0] yb);
    ifc.hand_x_left_top    = xt;
    ifc.hand_y_left_top    = yt;
    ifc.hand_x_left_bottom = xb;
    ifc.hand_y_left_bottom = yb;
  endtask

  // Leaves the bench at the negedge right after the strobe was sampled.
  task automatic pulse_strobe();
    @(negedge clk_65mhz);
    ifc.transmit_xy_update = 1'b1;
    @(negedge clk_65mhz);
    ifc.transmit_xy_update = 1'b0;
  endtask

  // Starts at a negedge; finds the first start-bit cycle, then samples each of the
  // 90 bit periods in its third cycle. Returns at the cycle right after the frame.
  task automatic capture_frame(output logic [71:0] rx, output int ferr, output bit found);
    int waited = 0;
    rx = '0;
    ferr = 0;
    found = 1'b0;
    while (ifc.uart_txd !== 1'b0 && waited < 2000) begin
      @(negedge clk_65mhz);
      waited++;
    end
    if (ifc.uart_txd !== 1'b0) return;
    found = 1'b1;
    for (int b = 0; b < 90; b++) begin
      int pos;
      int byt;
      pos = b % 10;
      byt = b / 10;
      repeat (2) @(negedge clk_65mhz);
      if (ifc.busy !== 1'b1) ferr++;
      if (pos == 0) begin
        if (ifc.uart_txd !== 1'b0) ferr++;
      end else if (pos == 9) begin
        if (ifc.uart_txd !== 1'b1) ferr++;
      end else begin
        rx[64 - 8 * byt + pos - 1] = ifc.uart_txd;
      end
      repeat (2) @(negedge clk_65mhz);
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    ifc.transmit_xy_update = 1'b0;
    set_coords(12'h0, 12'h0, 12'h0, 12'h0);
    repeat (3) @(negedge clk_65mhz);
    checks++;
    if (ifc.uart_txd !== 1'b1) begin failures++; $display("FAIL reset_txd: got %b expected 1", ifc.uart_txd); end
    checks++;
    if (ifc.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", ifc.busy); end
    checks++;
    if (ifc.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", ifc.done); end
    sys_rst = 1'b0;
    @(negedge clk_65mhz);
    set_coords(12'h111, 12'h222, 12'h333, 12'h444);
    pulse_strobe();
    checks++;
    if (ifc.uart_txd !== 1'b0 || ifc.busy !== 1'b1) begin
      failures++;
      $display("FAIL start_latency: got txd=%b busy=%b expected txd=0 busy=1", ifc.uart_txd, ifc.busy);
    end
    #2 sys_rst = 1'b1;
    #1;
    checks++;
    if (ifc.uart_txd !== 1'b1 || ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got txd=%b busy=%b done=%b expected 1 0 0", ifc.uart_txd, ifc.busy, ifc.done);
    end
    @(negedge clk_65mhz);
    sys_rst = 1'b0;
    @(negedge clk_65mhz);
  endtask

  task automatic test_single_frame();
    logic [71:0] rx;
    int ferr;
    bit found;
    int d0;
    set_coords(12'hABC, 12'h123, 12'h456, 12'h789);
    d0 = done_count;
    pulse_strobe();
    capture_frame(rx, ferr, found);
    checks++;
    if (!found || rx !== 72'hFFFFFF_ABC123_456789 || ferr != 0) begin
      failures++;
      $display("FAIL single_frame: got %h (found=%0d errs=%0d) expected ffffffabc123456789", rx, found, ferr);
    end
    checks++;
    if (ifc.done !== 1'b1 || ifc.busy !== 1'b0) begin
      failures++;
      $display("FAIL single_end_at_%0d: got done=%b busy=%b expected done=1 busy=0", FRAME_CYCLES, ifc.done, ifc.busy);
    end
    @(negedge clk_65mhz);
    checks++;
    if (ifc.done !== 1'b0 || done_count - d0 != 1) begin
      failures++;
      $display("FAIL single_done_pulse: got done=%b pulses=%0d expected done=0 pulses=1", ifc.done, done_count - d0);
    end
  endtask

  task automatic test_busy_strobe();
    logic [71:0] rx;
    int ferr;
    bit found;
    int d0;
    int bad;
    set_coords(12'h5A5, 12'h3C3, 12'h0F0, 12'hF0F);
    d0 = done_count;
    pulse_strobe();
    fork
      capture_frame(rx, ferr, found);
      begin
        repeat (50) @(negedge clk_65mhz);
        ifc.transmit_xy_update = 1'b1;
        set_coords(12'h0, 12'h0, 12'h0, 12'h0);
        @(negedge clk_65mhz);
        ifc.transmit_xy_update = 1'b0;
      end
    join
    checks++;
    if (!found || rx !== 72'hFFFFFF_5A53C3_0F0F0F || ferr != 0) begin
      failures++;
      $display("FAIL busy_strobe_frame: got %h (found=%0d errs=%0d) expected ffffff5a53c30f0f0f", rx, found, ferr);
    end
    bad = 0;
    repeat (400) begin
      @(negedge clk_65mhz);
      if (ifc.uart_txd !== 1'b1 || ifc.busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || done_count - d0 != 1) begin
      failures++;
      $display("FAIL busy_strobe_no_second: got active=%0d pulses=%0d expected active=0 pulses=1", bad, done_count - d0);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [71:0] rx;
    int ferr;
    bit found;
    int bad;
    set_coords(12'hABC, 12'h123, 12'h456, 12'h789);
    pulse_strobe();
    repeat (169) @(negedge clk_65mhz);
    checks++;
    if (ifc.uart_txd !== 1'b0 || ifc.busy !== 1'b1) begin
      failures++;
      $display("FAIL b4_bit1: got txd=%b busy=%b expected txd=0 busy=1", ifc.uart_txd, ifc.busy);
    end
    #2 sys_rst = 1'b1;
    #1;
    checks++;
    if (ifc.uart_txd !== 1'b1 || ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin
      failures++;
      $display("FAIL mid_frame_reset: got txd=%b busy=%b done=%b expected 1 0 0", ifc.uart_txd, ifc.busy, ifc.done);
    end
    @(negedge clk_65mhz);
    sys_rst = 1'b0;
    bad = 0;
    repeat (50) begin
      @(negedge clk_65mhz);
      if (ifc.uart_txd !== 1'b1 || ifc.busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL post_reset_idle: got active=%0d expected 0", bad);
    end
    set_coords(12'h012, 12'h345, 12'h678, 12'h9AB);
    pulse_strobe();
    capture_frame(rx, ferr, found);
    checks++;
    if (!found || rx !== 72'hFFFFFF_012345_6789AB || ferr != 0) begin
      failures++;
      $display("FAIL post_reset_frame: got %h (found=%0d errs=%0d) expected ffffff0123456789ab", rx, found, ferr);
    end
    @(negedge clk_65mhz);
  endtask

  task automatic test_back_to_back();
    logic [71:0] rx;
    int ferr;
    bit found;
    int d0;
    int bad;
    set_coords(12'hC0F, 12'hEE1, 12'h2D3, 12'hB4A);
    d0 = done_count;
    @(negedge clk_65mhz);
    ifc.transmit_xy_update = 1'b1;
    @(negedge clk_65mhz);
    for (int f = 0; f < 3; f++) begin
      checks++;
      if (ifc.uart_txd !== 1'b0 || ifc.busy !== 1'b1) begin
        failures++;
        $display("FAIL b2b_start_%0d: got txd=%b busy=%b expected txd=0 busy=1", f, ifc.uart_txd, ifc.busy);
      end
      if (f == 2) ifc.transmit_xy_update = 1'b0;
      capture_frame(rx, ferr, found);
      checks++;
      if (!found || rx !== 72'hFFFFFF_C0FEE1_2D3B4A || ferr != 0) begin
        failures++;
        $display("FAIL b2b_frame_%0d: got %h (found=%0d errs=%0d) expected ffffffc0fee12d3b4a", f, rx, found, ferr);
      end
      checks++;
      if (ifc.done !== 1'b1 || ifc.uart_txd !== 1'b1) begin
        failures++;
        $display("FAIL b2b_done_%0d: got done=%b txd=%b expected done=1 txd=1", f, ifc.done, ifc.uart_txd);
      end
      @(negedge clk_65mhz);
    end
    bad = 0;
    repeat (20) begin
      if (ifc.uart_txd !== 1'b1 || ifc.busy !== 1'b0) bad++;
      @(negedge clk_65mhz);
    end
    checks++;
    if (bad != 0 || done_count - d0 != 3) begin
      failures++;
      $display("FAIL b2b_stop: got active=%0d pulses=%0d expected active=0 pulses=3", bad, done_count - d0);
    end
  endtask

  task automatic test_all_ones();
    logic [71:0] rx;
    int ferr;
    bit found;
    set_coords(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);
    pulse_strobe();
    capture_frame(rx, ferr, found);
    checks++;
    if (!found || rx !== {72{1'b1}} || ferr != 0) begin
      failures++;
      $display("FAIL all_ones: got %h (found=%0d errs=%0d) expected ffffffffffffffffff", rx, found, ferr);
    end
    checks++;
    if (ifc.done !== 1'b1 || ifc.busy !== 1'b0) begin
      failures++;
      $display("FAIL all_ones_end: got done=%b busy=%b expected done=1 busy=0", ifc.done, ifc.busy);
    end
    @(negedge clk_65mhz);
  endtask

  initial begin
    $display("[TB] transmitter_camera_2 bench, CLKS_PER_BIT=%0d", CPB);
    test_reset();
    test_single_frame();
    test_busy_strobe();
    test_reset_mid_frame();
    test_back_to_back();
    test_all_ones();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
